// File: rtl/sigdel_seq.sv
// sigdel_seq - conversion sequencer for the sigma-delta ADC datapath.
//
// Purpose:
//   Latches the rate/oversampling/filter configuration, pulses a filter clear,
//   drops the filter outputs that arrive before the selected filter has
//   settled, then averages 2^navg filter outputs. The averaged result is
//   offered to a consumer over a valid/ready handshake. In continuous mode the
//   next conversion starts straight after each handshake. If the configuration
//   has changed, the sequencer re-clears and re-settles first. A watchdog
//   aborts a conversion when the filter stops producing outputs.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   start     conversion request, only looked at in IDLE
//   abort     cancel any conversion in progress
//   cont      continuous mode
//   cfg       {filter[1:0], osr[1:0], rate[1:0]} requested configuration
//   navg      average 2^navg filter outputs
//   eny       one-cycle strobe marking a new filter output on din
//   din       filter output
//   ready     consumer ready
//   cfg_o     configuration driven to the datapath
//   filt_clr  one-cycle filter clear pulse
//   busy      conversion in progress
//   result    averaged result (0 after a timeout)
//   valid     result valid
//   err       last conversion timed out
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// CLEAR  | filter clear pulse, discard count loaded from the filter type
// SETTLE | dropping filter outputs until the filter has settled
// ACCUM  | summing 2^navg filter outputs
// DONE   | result presented with valid=1 until the consumer takes it

module sigdel_seq #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1048576,
  parameter int TO_W    = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         cont,
  input  logic [5:0]   cfg,
  input  logic [1:0]   navg,
  input  logic         eny,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [5:0]   cfg_o,
  output logic         filt_clr,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         valid,
  output logic         err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] ACCUM  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // The watchdog counts down from TIMEOUT-1. It expires in the cycle it
  // reads zero, which is the TIMEOUT-th quiet cycle after the last reload.
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [1:0]      navg_r;
  logic [1:0]      disc;
  logic [2:0]      cnt;
  logic [W+2:0]    acc;
  logic [TO_W-1:0] to_cnt;

  logic [1:0]      disc_load;
  logic [2:0]      last_cnt;
  logic [W+2:0]    sum;
  logic [W-1:0]    avg;
  logic            to_expired;

  // Status outputs follow the state directly.
  assign filt_clr   = (state == CLEAR);
  assign busy       = (state != IDLE);
  assign valid      = (state == DONE);
  assign to_expired = (to_cnt == '0);

  // Filter outputs to drop before the filter has settled: AVG and SINC1 need
  // one, SINC2 two, SINC3 three.
  always_comb begin
    disc_load = 2'd1;
    case (cfg_o[5:4])
      2'b10:   disc_load = 2'd2;
      2'b11:   disc_load = 2'd3;
      default: disc_load = 2'd1;
    endcase
  end

  // Index of the final sample of an average.
  always_comb begin
    last_cnt = 3'd0;
    case (navg_r)
      2'd0:    last_cnt = 3'd0;
      2'd1:    last_cnt = 3'd1;
      2'd2:    last_cnt = 3'd3;
      default: last_cnt = 3'd7;
    endcase
  end

  // Running sum including the current sample. The accumulator has three
  // extra bits, so eight full-scale samples cannot overflow. The divide is a
  // truncating shift, done as a fixed slice for each navg.
  assign sum = acc + (W+3)'(din);

  always_comb begin
    avg = sum[W-1:0];
    case (navg_r)
      2'd0:    avg = sum[W-1:0];
      2'd1:    avg = sum[W:1];
      2'd2:    avg = sum[W+1:2];
      default: avg = sum[W+2:3];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cfg_o  <= '0;
      navg_r <= '0;
      disc   <= '0;
      cnt    <= '0;
      acc    <= '0;
      to_cnt <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      // Leave cfg_o and err alone. The next start reloads everything that
      // matters.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            cfg_o  <= cfg;
            navg_r <= navg;
            err    <= 1'b0;
            state  <= CLEAR;
          end
        end

        CLEAR: begin
          // Any eny in this cycle belongs to the old filter contents and is
          // ignored.
          disc   <= disc_load;
          to_cnt <= TO_LOAD;
          state  <= SETTLE;
        end

        SETTLE: begin
          if (eny) begin
            to_cnt <= TO_LOAD;
            if (disc == 2'd1) begin
              acc   <= '0;
              cnt   <= '0;
              state <= ACCUM;
            end else begin
              disc <= disc - 2'd1;
            end
          end else if (to_expired) begin
            result <= '0;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end

        ACCUM: begin
          if (eny) begin
            to_cnt <= TO_LOAD;
            if (cnt == last_cnt) begin
              result <= avg;
              state  <= DONE;
            end else begin
              acc <= sum;
              cnt <= cnt + 3'd1;
            end
          end else if (to_expired) begin
            result <= '0;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end

        DONE: begin
          // eny strobes here are dropped. result is held until it is taken.
          if (ready) begin
            if (!cont) begin
              state <= IDLE;
            end else if (cfg == cfg_o) begin
              // The filter is already settled for this configuration.
              acc    <= '0;
              cnt    <= '0;
              to_cnt <= TO_LOAD;
              state  <= ACCUM;
            end else begin
              cfg_o  <= cfg;
              navg_r <= navg;
              err    <= 1'b0;
              state  <= CLEAR;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdel_seq.sv
module tb_sigdel_seq;

  localparam int W       = 16;
  localparam int TIMEOUT = 64;
  localparam int TO_W    = 7;

  logic         clk = 1'b0;
  logic         rst, start, abort, cont, eny, ready;
  logic [5:0]   cfg;
  logic [1:0]   navg;
  logic [W-1:0] din;
  logic [5:0]   cfg_o;
  logic         filt_clr, busy, valid, err;
  logic [W-1:0] result;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sigdel_seq #(.W(W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
    .cfg(cfg), .navg(navg), .eny(eny), .din(din), .ready(ready),
    .cfg_o(cfg_o), .filt_clr(filt_clr), .busy(busy), .result(result),
    .valid(valid), .err(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  // ---------------- stimulus helpers and reference rules ----------------

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_eny(input logic [W-1:0] d, input int gap);
    eny = 1'b1;
    din = d;
    tick();
    eny = 1'b0;
    din = W'($urandom);
    repeat (gap) tick();
  endtask

  // Leaves the DUT in its CLEAR cycle.
  task automatic start_conv(input logic [5:0] c, input logic [1:0] n);
    cfg   = c;
    navg  = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int n_disc(input logic [5:0] c);
    if (c[5:4] == 2'b11) return 3;
    if (c[5:4] == 2'b10) return 2;
    return 1;
  endfunction

  // ---------------- tests ----------------

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    cfg   = 6'b111111;
    tick();
    tick();
    checks++;
    if ({cfg_o, filt_clr, busy, valid, err} !== 10'd0) begin
      errs++;
      $display("FAIL reset_ctrl: got %b expected 0", {cfg_o, filt_clr, busy, valid, err});
    end
    checks++;
    if (result !== '0) begin
      errs++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start_conv(6'b000000, 2'd0);
    checks++;
    if (filt_clr !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL basic_clear: filt_clr=%b busy=%b expected 1 1", filt_clr, busy);
    end
    tick();
    checks++;
    if (filt_clr !== 1'b0) begin
      errs++;
      $display("FAIL basic_clr_width: filt_clr=%b expected 0", filt_clr);
    end
    send_eny(16'h1234, 0);
    checks++;
    if (valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_discard: valid=%b expected 0", valid);
    end
    send_eny(16'h1234, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'h1234) begin
      errs++;
      $display("FAIL basic_result: valid=%b result=%h expected 1 1234", valid, result);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_handshake: valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_hold();
    start_conv(6'b110000, 2'd2);
    eny = 1'b1;            // strobe during CLEAR must be ignored
    din = 16'd999;
    tick();
    eny = 1'b0;
    for (int i = 0; i < 3; i++) send_eny(W'($urandom), 1);
    send_eny(16'd10, 0);
    send_eny(16'd20, 2);
    send_eny(16'd30, 1);
    send_eny(16'd41, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'd25) begin
      errs++;
      $display("FAIL hold_result: valid=%b result=%0d expected 1 25", valid, result);
    end
    for (int i = 0; i < 5; i++) begin
      eny = 1'b1;
      din = W'($urandom);
      tick();
      checks++;
      if (valid !== 1'b1 || result !== 16'd25) begin
        errs++;
        $display("FAIL hold_stable: cycle %0d valid=%b result=%0d expected 1 25", i, valid, result);
      end
    end
    eny   = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      errs++;
      $display("FAIL hold_release: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_back_to_back();
    cont = 1'b1;
    start_conv(6'b100101, 2'd1);
    tick();
    send_eny(W'($urandom), 1);
    send_eny(W'($urandom), 0);
    send_eny(16'd100, 1);
    send_eny(16'd200, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'd150) begin
      errs++;
      $display("FAIL cont_first: valid=%b result=%0d expected 1 150", valid, result);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || filt_clr !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL cont_reenter: valid=%b filt_clr=%b busy=%b expected 0 0 1", valid, filt_clr, busy);
    end
    send_eny(16'd100, 0);
    send_eny(16'd200, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'd150) begin
      errs++;
      $display("FAIL cont_second: valid=%b result=%0d expected 1 150", valid, result);
    end
    cfg   = 6'b010000;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (filt_clr !== 1'b1 || cfg_o !== 6'b010000 || valid !== 1'b0) begin
      errs++;
      $display("FAIL cont_newcfg: filt_clr=%b cfg_o=%b valid=%b expected 1 010000 0", filt_clr, cfg_o, valid);
    end
    tick();
    checks++;
    if (filt_clr !== 1'b0) begin
      errs++;
      $display("FAIL cont_clr_once: filt_clr=%b expected 0", filt_clr);
    end
    send_eny(16'd55, 0);
    checks++;
    if (valid !== 1'b0) begin
      errs++;
      $display("FAIL cont_discard: valid=%b expected 0", valid);
    end
    send_eny(16'd7, 0);
    send_eny(16'd9, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'd8) begin
      errs++;
      $display("FAIL cont_third: valid=%b result=%0d expected 1 8", valid, result);
    end
    cont  = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL cont_stop: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_conv(6'b100000, 2'd0);
    n = 0;
    while (valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    // one cycle to leave CLEAR, then TIMEOUT quiet cycles in SETTLE
    checks++;
    if (n !== TIMEOUT + 1) begin
      errs++;
      $display("FAIL timeout_latency: cycles=%0d expected %0d", n, TIMEOUT + 1);
    end
    checks++;
    if (err !== 1'b1 || result !== '0) begin
      errs++;
      $display("FAIL timeout_flags: err=%b result=%h expected 1 0", err, result);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (err !== 1'b1 || valid !== 1'b0) begin
      errs++;
      $display("FAIL timeout_sticky: err=%b valid=%b expected 1 0", err, valid);
    end
    start_conv(6'b000000, 2'd0);
    checks++;
    if (err !== 1'b0) begin
      errs++;
      $display("FAIL timeout_clear: err=%b expected 0", err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    start_conv(6'b100000, 2'd2);
    tick();
    send_eny(W'($urandom), 0);
    send_eny(W'($urandom), 0);
    send_eny(16'd1000, 0);
    send_eny(16'd2000, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || filt_clr !== 1'b0 || cfg_o !== 6'b100000) begin
      errs++;
      $display("FAIL abort_idle: busy=%b valid=%b filt_clr=%b cfg_o=%b expected 0 0 0 100000", busy, valid, filt_clr, cfg_o);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_with_start: busy=%b expected 0", busy);
    end
    start_conv(6'b100000, 2'd2);
    tick();
    send_eny(W'($urandom), 0);
    send_eny(W'($urandom), 0);
    send_eny(16'd4, 0);
    send_eny(16'd8, 1);
    send_eny(16'd12, 0);
    send_eny(16'd16, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'd10) begin
      errs++;
      $display("FAIL abort_restart: valid=%b result=%0d expected 1 10", valid, result);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_busy_start_and_rst();
    start_conv(6'b010100, 2'd0);
    tick();
    cfg   = 6'b111111;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (cfg_o !== 6'b010100 || busy !== 1'b1 || filt_clr !== 1'b0) begin
      errs++;
      $display("FAIL busy_start: cfg_o=%b busy=%b filt_clr=%b expected 010100 1 0", cfg_o, busy, filt_clr);
    end
    send_eny(16'h0001, 0);
    send_eny(16'hBEEF, 0);
    checks++;
    if (valid !== 1'b1 || result !== 16'hBEEF) begin
      errs++;
      $display("FAIL busy_result: valid=%b result=%h expected 1 beef", valid, result);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cfg_o, filt_clr, busy, valid, err} !== 10'd0 || result !== '0) begin
      errs++;
      $display("FAIL rst_in_done: ctrl=%b result=%h expected 0 0", {cfg_o, filt_clr, busy, valid, err}, result);
    end
  endtask

  task automatic test_random();
    logic [5:0]   c;
    logic [1:0]   n;
    logic [W-1:0] d;
    int           sum;
    int           nsamp;
    int           expv;
    for (int it = 0; it < 25; it++) begin
      c = 6'($urandom);
      n = 2'($urandom);
      start_conv(c, n);
      if ($urandom_range(1, 0) == 1) begin
        eny = 1'b1;
        din = W'($urandom);
      end
      tick();
      eny = 1'b0;
      for (int k = 0; k < n_disc(c); k++) send_eny(W'($urandom), $urandom_range(2, 0));
      nsamp = 1 << n;
      sum   = 0;
      for (int k = 0; k < nsamp; k++) begin
        d = W'($urandom);
        sum += int'(d);
        send_eny(d, (k == nsamp - 1) ? 0 : $urandom_range(2, 0));
      end
      expv = sum / nsamp;
      checks++;
      if (valid !== 1'b1 || result !== W'(expv) || err !== 1'b0) begin
        errs++;
        $display("FAIL random_avg: iter %0d cfg=%b navg=%0d valid=%b err=%b result=%0d expected 1 0 %0d",
                 it, c, n, valid, err, result, expv);
      end
      repeat ($urandom_range(3, 0)) tick();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errs++;
        $display("FAIL random_release: iter %0d busy=%b valid=%b expected 0 0", it, busy, valid);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cont  = 1'b0;
    eny   = 1'b0;
    ready = 1'b0;
    cfg   = '0;
    navg  = '0;
    din   = '0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_busy_start_and_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sigdel_seq.md
Name: sigdel_seq

Overview:
Conversion sequencer for the sigma-delta ADC datapath. It latches a rate, oversampling and filter configuration and drives it to the datapath. It clears the filter, discards outputs until the selected filter has settled, then averages 1/2/4/8 filter outputs. The averaged 16-bit result goes to a consumer over a valid/ready handshake, e.g. the serial transmitter or a register interface.

Parameters:
W, 16, width of the filter output and of the result
TIMEOUT, 1048576, clk cycles without an eny strobe before a conversion is aborted with err
TO_W, 21, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  conversion request; sampled only in IDLE
abort  in  1  cancels any conversion in progress
cont  in  1  continuous mode
cfg  in  6  {filter[1:0], osr[1:0], rate[1:0]}; same field order as the datapath select inputs
navg  in  2  averages 2^navg filter outputs
eny  in  1  one-clk strobe marking each new filter output
din  in  W  filter output, valid in the cycle eny=1
ready  in  1  consumer ready
cfg_o  out  6  registered configuration driven to the datapath
filt_clr  out  1  one-cycle filter clear pulse
busy  out  1  conversion in progress
result  out  W  averaged result
valid  out  1  result valid
err  out  1  last conversion timed out

Behaviour:
Interface: one clock; reset is synchronous and active-high.

Reset (rst=1 at a clk edge):
- state=IDLE
- cfg_o=0, filt_clr=0, busy=0, result=0, valid=0, err=0
- all counters and the accumulator = 0

States:
- IDLE: busy=0. If start=1 and abort=0: latch cfg into cfg_o, latch navg, clear err, go to CLEAR. start while busy is ignored.
- CLEAR: exactly 1 cycle with filt_clr=1. Load the discard count from cfg_o[5:4]: 00 (AVG)=1, 01 (SINC1)=1, 10 (SINC2)=2, 11 (SINC3)=3. Go to SETTLE.
- SETTLE: each eny decrements the discard count. The eny that brings it to 0 is discarded. Go to ACCUM with acc=0, cnt=0.
- ACCUM: each eny does acc+=din (acc is W+3 bits, no overflow possible) and cnt++. On the eny where cnt==2^navg-1: result=(acc+din)>>navg (truncating), valid=1, go to DONE.
- DONE: valid=1 and result held stable until ready=1. eny strobes in DONE are dropped.
- On handshake (valid&ready):
  - valid=0 next cycle.
  - cont=0 → IDLE.
  - cont=1 and cfg==cfg_o → ACCUM directly, no re-settle.
  - cont=1 and cfg!=cfg_o → latch new cfg and navg, go to CLEAR.
- busy=1 in CLEAR, SETTLE, ACCUM and DONE.

Latency:
- start sampled at edge t → filt_clr=1 during cycle t+1 → SETTLE from t+2.
- valid rises the cycle after the final accumulated eny.

Timeout:
- Counter cleared on entry to SETTLE/ACCUM and on every eny.
- Reaching TIMEOUT-1 in SETTLE or ACCUM → DONE with result=0, err=1, valid=1.
- err stays set until the next accepted start (or cont re-entry to CLEAR).

Abort:
- Highest priority after rst. In any non-IDLE state → IDLE next cycle: valid=0, busy=0, filt_clr=0, err unchanged, cfg_o retained.
- abort and start together in IDLE: stays IDLE.

Simultaneous events:
- eny in the CLEAR cycle is ignored.
- eny in the same cycle as the transition SETTLE→ACCUM counts only toward SETTLE.
- ready without valid has no effect.

Test Plan:
- cfg=6'b000000, navg=0, start; eny with din=0x1234 → filt_clr 1 cycle at t+1; first eny discarded; second eny gives result=0x1234, valid=1; ready → IDLE, busy=0.
- cfg=6'b110000 (SINC3), navg=2; 3 eny discarded, then din=10,20,30,41 → result=25 (101>>2); hold ready=0 for 5 cycles with extra eny → result stays 25, valid stays 1.
- cont=1, cfg unchanged, navg=1, din=100,200 per conversion → back-to-back results 150 with no filt_clr between them; then change cfg to 6'b010000 before ready → filt_clr pulses once, cfg_o=6'b010000, 1 discard.
- TIMEOUT=64, start, no eny → valid=1, err=1, result=0 after CLEAR+64 cycles; next start clears err.
- abort asserted mid-ACCUM after 2 of 4 eny → IDLE next cycle, valid=0; new start re-settles and produces a correct average with no residue from the first accumulation.
- rst asserted in DONE with valid=1 → all outputs 0 next cycle; start asserted while busy in SETTLE → ignored, cfg_o unchanged.
